// File: rtl/keypad_pkg.sv
// Shared types and legacy key codes for the scanned keypad controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  // Legacy 5-bit codes: bit4 flags a pressed key, the low nibble names it.
  localparam logic [4:0] KEY_NONE  = 5'h00;
  localparam logic [4:0] KEY_0     = 5'h10;
  localparam logic [4:0] KEY_1     = 5'h11;
  localparam logic [4:0] KEY_2     = 5'h12;
  localparam logic [4:0] KEY_3     = 5'h13;
  localparam logic [4:0] KEY_4     = 5'h14;
  localparam logic [4:0] KEY_5     = 5'h15;
  localparam logic [4:0] KEY_6     = 5'h16;
  localparam logic [4:0] KEY_7     = 5'h17;
  localparam logic [4:0] KEY_8     = 5'h18;
  localparam logic [4:0] KEY_9     = 5'h19;
  localparam logic [4:0] KEY_A     = 5'h1A;
  localparam logic [4:0] KEY_B     = 5'h1B;
  localparam logic [4:0] KEY_C     = 5'h1C;
  localparam logic [4:0] KEY_D     = 5'h1D;
  localparam logic [4:0] KEY_STAR  = 5'h1E;
  localparam logic [4:0] KEY_SHARP = 5'h1F;

  // Row-major 4x4 layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
  function automatic logic [4:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:    key_map = KEY_1;
      4'd1:    key_map = KEY_2;
      4'd2:    key_map = KEY_3;
      4'd3:    key_map = KEY_A;
      4'd4:    key_map = KEY_4;
      4'd5:    key_map = KEY_5;
      4'd6:    key_map = KEY_6;
      4'd7:    key_map = KEY_B;
      4'd8:    key_map = KEY_7;
      4'd9:    key_map = KEY_8;
      4'd10:   key_map = KEY_9;
      4'd11:   key_map = KEY_C;
      4'd12:   key_map = KEY_STAR;
      4'd13:   key_map = KEY_0;
      4'd14:   key_map = KEY_SHARP;
      4'd15:   key_map = KEY_D;
      default: key_map = KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Counts consecutive matching cycles; done holds once N matches are seen
// and drops on the first mismatch or restart.
module key_debounce #(
  parameter int N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic match,
  output logic done
);

  localparam int W = $clog2(N + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !match) begin
      cnt_d = '0;
    end else if (cnt_q != W'(N)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(N));

endmodule

// File: rtl/keypad_scanner.sv
// Actively scanned matrix keypad: one-hot row drive, synchronised column
// sense, press/release debounce, ghost rejection and a valid/ack event port.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20,
  parameter int IDX_W    = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ROWS-1:0]  row_drv,
  input  logic [COLS-1:0]  col_in,
  output logic [IDX_W-1:0] key_idx,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_held,
  output logic             overrun
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW_W  = $clog2(SCAN_DIV);

  logic [COLS-1:0]  sync1_q, col_s_q;
  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, row_next;
  logic [COL_W-1:0] col_q, col_d, hot_col;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [IDX_W-1:0] key_idx_q, key_idx_d, new_idx;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             overrun_q, overrun_d;
  logic [COLS-1:0]  col_mask;
  logic             one_hot, accept;
  logic             db_restart, db_match, db_done;

  // Two-flop synchroniser for the asynchronous column pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      col_s_q <= '0;
    end else begin
      sync1_q <= col_in;
      col_s_q <= sync1_q;
    end
  end

  always_comb begin
    hot_col = '0;
    for (int i = 0; i < COLS; i++) begin
      if (col_s_q[i]) hot_col = COL_W'(i);
    end
  end

  assign one_hot  = $onehot(col_s_q);
  assign col_mask = COLS'(1) << col_q;
  assign row_next = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign new_idx  = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);

  // One counter serves both debounce phases; it idles cleared elsewhere.
  assign db_restart = !(state_q == PRESS_DB || state_q == RELEASE_DB);
  assign db_match   = (state_q == PRESS_DB) ? (col_s_q == col_mask) : !col_s_q[col_q];

  key_debounce #(.N(DEBOUNCE)) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .restart (db_restart),
    .match   (db_match),
    .done    (db_done)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    dwell_d    = dwell_q;
    key_held_d = key_held_q;
    accept     = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DW_W'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          if (one_hot) begin
            col_d   = hot_col;
            state_d = PRESS_DB;
          end else begin
            row_d = row_next;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (db_done) begin
          accept     = 1'b1;
          key_held_d = 1'b1;
          state_d    = PRESSED;
        end else if (!db_match) begin
          row_d   = row_next;
          state_d = SCAN;
        end
      end
      PRESSED: begin
        if (!col_s_q[col_q]) state_d = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (db_done) begin
          key_held_d = 1'b0;
          row_d      = row_next;
          dwell_d    = '0;
          state_d    = SCAN;
        end else if (col_s_q[col_q]) begin
          state_d = PRESSED;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // An ack in the acceptance cycle frees the slot for the new index at once.
  always_comb begin
    key_idx_d   = key_idx_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (key_ack) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (accept) begin
      if (!key_valid_q || key_ack) begin
        key_idx_d   = new_idx;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= '0;
      col_q       <= '0;
      dwell_q     <= '0;
      key_idx_q   <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      key_idx_q   <= key_idx_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      overrun_q   <= overrun_d;
    end
  end

  assign row_drv   = ROWS'(1) << row_q;
  assign key_idx   = key_idx_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and an event scoreboard.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEBOUNCE = 4;
  localparam int IDX_W    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [ROWS-1:0]  row_drv;
  logic [COLS-1:0]  col_in;
  logic [IDX_W-1:0] key_idx;
  logic             key_valid;
  logic             key_ack;
  logic             key_held;
  logic             overrun;

  logic [ROWS*COLS-1:0] keys_down;
  logic                 prev_valid = 1'b0;
  int                   n_checks = 0;
  int                   n_fail   = 0;
  int                   n_rises  = 0;
  int                   sb_q[$];
  int                   rises0;
  int                   lat;

  always #5 clk = ~clk;

  // Pressed keys short their column to the driven row.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (row_drv[r] && keys_down[r*COLS+c]) col_in[c] = 1'b1;
      end
    end
  end

  keypad_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE),
    .IDX_W    (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_drv   (row_drv),
    .col_in    (col_in),
    .key_idx   (key_idx),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and score any new key_valid rise against the queue.
  task automatic step();
    int exp_idx;
    @(negedge clk);
    if (key_valid === 1'b1 && prev_valid !== 1'b1) begin
      n_rises++;
      check("event_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_idx = sb_q.pop_front();
        check("event_idx", 32'(key_idx), 32'(exp_idx));
      end
    end
    prev_valid = key_valid;
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
  endtask

  task automatic wait_held(input logic val, input int budget, input string tag);
    for (int i = 0; i < budget && key_held !== val; i++) step();
    check(tag, 32'(key_held), 32'(val));
  endtask

  task automatic wait_rise(input int target, input string tag);
    for (int i = 0; i < 80 && n_rises < target; i++) step();
    check(tag, 32'(n_rises), 32'(target));
  endtask

  // Waits for a fresh entry into the target row, i.e. dwell cycle 0.
  task automatic wait_row(input logic [ROWS-1:0] target, input string tag);
    for (int i = 0; i < 80 && row_drv === target; i++) step();
    for (int i = 0; i < 80 && row_drv !== target; i++) step();
    check(tag, 32'(row_drv), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row"},   32'(row_drv),   32'b0001);
    check({tag, "_idx"},   32'(key_idx),   32'd0);
    check({tag, "_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_held"},  32'(key_held),  32'd0);
    check({tag, "_ovr"},   32'(overrun),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    key_ack   = 1'b0;
    keys_down = '0;
    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b0;

    // Idle scan: 8-cycle dwell per row, wrapping after row 3.
    for (int k = 0; k < 40; k++) begin
      check("idle_row", 32'(row_drv), 32'(1) << ((k / SCAN_DIV) % ROWS));
      step();
    end
    check("idle_valid", 32'(key_valid), 32'd0);
    check("idle_held",  32'(key_held),  32'd0);

    // Single press of key 9 (row 2, col 1), latency from row entry.
    keys_down[9] = 1'b1;
    sb_q.push_back(9);
    wait_row(4'b0100, "t2_row2");
    lat = 0;
    while (key_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    check("t2_latency", 32'(lat), 32'(SCAN_DIV + DEBOUNCE + 1));
    check("t2_keymap",  32'(key_map(key_idx)), 32'(KEY_8));
    check("t2_held",    32'(key_held), 32'd1);
    repeat (10) step();
    check("t2_frozen",     32'(row_drv),   32'b0100);
    check("t2_idx_stable", 32'(key_idx),   32'd9);
    check("t2_valid_hold", 32'(key_valid), 32'd1);
    ack_pulse();
    check("t2_ack_valid", 32'(key_valid), 32'd0);
    keys_down[9] = 1'b0;
    repeat (DEBOUNCE) step();
    check("t2_release_db", 32'(key_held), 32'd1);
    wait_held(1'b0, 20, "t2_released");
    check("t2_next_row", 32'(row_drv), 32'b1000);

    // Bouncing key 5: no event while bouncing, exactly one once stable.
    rises0 = n_rises;
    for (int i = 0; i < 10; i++) begin
      keys_down[5] = ~keys_down[5];
      step();
      step();
    end
    check("t3_no_bounce_event", 32'(n_rises), 32'(rises0));
    sb_q.push_back(5);
    keys_down[5] = 1'b1;
    wait_rise(rises0 + 1, "t3_event");
    repeat (20) step();
    check("t3_one_event", 32'(n_rises), 32'(rises0 + 1));
    check("t3_held", 32'(key_held), 32'd1);
    ack_pulse();
    keys_down[5] = 1'b0;
    wait_held(1'b0, 20, "t3_released");

    // Ghost reading 0101 on row 0: rejected, scan moves on after the dwell.
    rises0 = n_rises;
    keys_down[0] = 1'b1;
    keys_down[2] = 1'b1;
    wait_row(4'b0001, "t4_row0");
    repeat (SCAN_DIV - 1) step();
    check("t4_dwell_end", 32'(row_drv), 32'b0001);
    step();
    check("t4_advance", 32'(row_drv),   32'b0010);
    check("t4_valid",   32'(key_valid), 32'd0);
    check("t4_held",    32'(key_held),  32'd0);
    check("t4_no_event", 32'(n_rises),  32'(rises0));
    keys_down = '0;

    // Second press while the first is unacknowledged is dropped.
    rises0 = n_rises;
    sb_q.push_back(0);
    keys_down[0] = 1'b1;
    wait_rise(rises0 + 1, "t5_event");
    keys_down[0] = 1'b0;
    wait_held(1'b0, 20, "t5_rel0");
    keys_down[15] = 1'b1;
    wait_held(1'b1, 80, "t5_press15");
    check("t5_overrun", 32'(overrun),   32'd1);
    check("t5_idx",     32'(key_idx),   32'd0);
    check("t5_valid",   32'(key_valid), 32'd1);
    keys_down[15] = 1'b0;
    wait_held(1'b0, 20, "t5_rel15");
    check("t5_sticky", 32'(overrun), 32'd1);
    ack_pulse();
    check("t5_ack_valid", 32'(key_valid), 32'd0);
    check("t5_ack_ovr",   32'(overrun),   32'd0);

    // Ack landing in the acceptance cycle of key 10 keeps valid high.
    rises0 = n_rises;
    sb_q.push_back(6);
    keys_down[6] = 1'b1;
    wait_rise(rises0 + 1, "t6_event");
    keys_down[6] = 1'b0;
    wait_held(1'b0, 20, "t6_rel6");
    wait_row(4'b0100, "t6_row2");
    keys_down[10] = 1'b1;
    repeat (SCAN_DIV + DEBOUNCE) step();
    check("t6_idx_before", 32'(key_idx), 32'd6);
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    check("t6_valid", 32'(key_valid), 32'd1);
    check("t6_idx",   32'(key_idx),   32'd10);
    check("t6_ovr",   32'(overrun),   32'd0);
    check("t6_held",  32'(key_held),  32'd1);

    // Reset while PRESSED.
    reset = 1'b1;
    step();
    check_reset_outputs("t7_reset");
    keys_down = '0;
    reset = 1'b0;
    repeat (SCAN_DIV) step();
    check("t7_rescan", 32'(row_drv), 32'b0010);
    check("sb_empty",  32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
